// File: rtl/pwm_pkg.sv
// Shared duty-path definitions for the SPI register bank, pwm_duty_ramp and
// pwm_peripheral.
//   DUTY_W   : width of duty values, shared with pwm_peripheral
//   DIV_W    : width of the ramp rate divider
//   STEP_W   : width of the per-tick step size
//   DUTY_MAX : largest representable duty value
//   duty_t   : duty value type used across the duty path
package pwm_pkg;

  localparam int DUTY_W = 8;
  localparam int DIV_W  = 16;
  localparam int STEP_W = 4;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_MAX = '1;

endpackage

// File: rtl/ramp_prescaler.sv
// Rate prescaler for the duty ramp. Produces a one-cycle tick every eff_div
// running edges, where eff_div is div with 0 treated as 1.
//   clk    : system clock
//   rst_n  : synchronous active-low reset, clears the count
//   run    : ramp is active; when low the count clears
//   freeze : hold the count exactly (takes priority over run)
//   div    : clocks per tick; may change at any time
//   tick   : high on the edge at which the count wraps
module ramp_prescaler #(
  parameter int DIV_W = pwm_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             freeze,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  import pwm_pkg::*;

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] last;
  logic             wrap;

  // eff_div-1; a divider of 0 behaves as 1, so every running edge ticks.
  assign last = (div == '0) ? '0 : div - DIV_W'(1);

  // ">=" rather than "==" so that shrinking div below the current count
  // wraps on the next edge instead of running round the full counter.
  assign wrap = (count_q >= last);
  assign tick = run & ~freeze & wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (freeze) begin
      count_q <= count_q;
    end else if (!run) begin
      count_q <= '0;
    end else if (wrap) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start / slew limiter between the SPI register bank and pwm_peripheral.
// Moves duty_out toward the registered target in steps of at most eff_step,
// one step per prescaler tick, never overshooting. Bypass forwards target_q.
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   target_duty : duty written over SPI (registered into target_q)
//   ramp_en     : 1 = ramped tracking, 0 = bypass
//   hold        : freezes duty_out and the prescaler
//   ramp_div    : clocks per ramp tick, 0 treated as 1
//   step        : duty increment per tick, 0 treated as 1
//   duty_out    : registered duty to pwm_peripheral
//   busy        : ramp in progress
//   at_target   : duty_out equals target_q
module pwm_duty_ramp #(
  parameter int DUTY_W = pwm_pkg::DUTY_W,
  parameter int DIV_W  = pwm_pkg::DIV_W,
  parameter int STEP_W = pwm_pkg::STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              ramp_en,
  input  logic              hold,
  input  logic [DIV_W-1:0]  ramp_div,
  input  logic [STEP_W-1:0] step,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              at_target
);

  import pwm_pkg::*;

  logic [DUTY_W-1:0] target_q;
  logic [DUTY_W-1:0] duty_q;
  logic              run;
  logic              tick;

  logic [STEP_W-1:0] eff_step;
  logic              up;
  logic [DUTY_W:0]   gap;
  logic [DUTY_W:0]   step_x;
  logic [DUTY_W:0]   inc;
  logic [DUTY_W:0]   stepped;
  logic [DUTY_W-1:0] duty_next;
  logic              unused_stepped_msb;

  assign at_target = (duty_q == target_q);
  assign run       = ramp_en & ~at_target;
  assign busy      = run & ~hold;
  assign duty_out  = duty_q;

  ramp_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .freeze (hold),
    .div    (ramp_div),
    .tick   (tick)
  );

  // Step arithmetic is one bit wider than the duty so the distance to the
  // target is exact; clamping the increment to that distance is what
  // prevents overshoot and any wrap past 0 or the top code.
  assign eff_step = (step == '0) ? STEP_W'(1) : step;
  assign up       = (target_q > duty_q);
  assign gap      = up ? ({1'b0, target_q} - {1'b0, duty_q})
                       : ({1'b0, duty_q} - {1'b0, target_q});
  assign step_x   = (DUTY_W+1)'(eff_step);
  assign inc      = (step_x < gap) ? step_x : gap;
  assign stepped  = up ? ({1'b0, duty_q} + inc) : ({1'b0, duty_q} - inc);

  // The clamp keeps the result inside the duty range, so the extra bit is 0.
  assign duty_next          = stepped[DUTY_W-1:0];
  assign unused_stepped_msb = stepped[DUTY_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
      duty_q   <= '0;
    end else begin
      target_q <= target_duty;
      if (hold) begin
        duty_q <= duty_q;
      end else if (!ramp_en) begin
        duty_q <= target_q;
      end else if (tick) begin
        duty_q <= duty_next;
      end
    end
  end

endmodule
